// File: rtl/uart_timer_pkg.sv
// Shared types and constants for the UART receive bit-timing engine.
// Bit-type decode lives here so the frame sequencer stays compact.
package uart_timer_pkg;

  typedef enum logic [1:0] {
    START  = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } bit_type_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MIN_DIVISOR   = 2;
  localparam int MIN_DATA_BITS = 5;

  function automatic bit_type_t decode_type(
    input logic [3:0] idx,
    input logic [3:0] nd,
    input logic       par
  );
    bit_type_t t;
    if (idx == 4'd0)
      t = START;
    else if (idx <= nd)
      t = DATA;
    else if (par && idx == nd + 4'd1)
      t = PARITY;
    else
      t = STOP;
    return t;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Loadable down-counter; tc is high while the count sits at zero.
// Load takes priority over the decrement.
module uart_baud_counter #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             enable,
  output logic             tc
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (enable && cnt_q != '0)
      cnt_d = cnt_q - DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/uart_frame_timer.sv
// Programmable UART receive frame timer: centred per-bit strobes,
// bit index/type reporting and end-of-frame pulse.
module uart_frame_timer
  import uart_timer_pkg::*;
#(
  parameter int DIV_W         = 16,
  parameter int MAX_DATA_BITS = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] divisor,
  input  logic [3:0]       data_bits,
  input  logic             parity_en,
  input  logic             two_stop,
  output logic             sample_strobe,
  output logic [3:0]       bit_index,
  output bit_type_t        bit_type,
  output logic             packet_done,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       nd_q, nd_d;
  logic [3:0]       nbits_q, nbits_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic             par_q, par_d;
  logic             strobe_q, strobe_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [3:0]       idx_q, idx_d;
  bit_type_t        type_q, type_d;

  logic [DIV_W-1:0] div_in, half_in, cnt_val;
  logic [3:0]       nd_in, nbits_in;
  logic             accept, fire, first_now;
  logic             cnt_load, cnt_en, tc;

  always_comb begin
    div_in = (divisor < DIV_W'(MIN_DIVISOR)) ? DIV_W'(MIN_DIVISOR)
                                             : divisor;
    half_in = div_in >> 1;
    if (data_bits < 4'(MIN_DATA_BITS))
      nd_in = 4'(MIN_DATA_BITS);
    else if (data_bits > 4'(MAX_DATA_BITS))
      nd_in = 4'(MAX_DATA_BITS);
    else
      nd_in = data_bits;
    nbits_in = 4'd1 + nd_in + {3'b000, parity_en}
             + (two_stop ? 4'd2 : 4'd1);
  end

  // Strobe asserts the cycle after terminal count, so reloads are one
  // short; a half-bit of 1 must strobe straight off the start edge.
  assign accept    = (state_q == IDLE) && start && !abort;
  assign fire      = (state_q == RUN) && tc && !abort && !done_q;
  assign first_now = (half_in == DIV_W'(1));
  assign cnt_load  = accept || fire;
  assign cnt_en    = (state_q == RUN);

  always_comb begin
    if (fire)
      cnt_val = div_q - DIV_W'(1);
    else if (first_now)
      cnt_val = div_in - DIV_W'(1);
    else
      cnt_val = half_in - DIV_W'(2);
  end

  uart_baud_counter #(
    .DIV_W (DIV_W)
  ) u_baud_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .enable   (cnt_en),
    .tc       (tc)
  );

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    nd_d      = nd_q;
    nbits_d   = nbits_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    strobe_d  = 1'b0;
    done_d    = 1'b0;
    busy_d    = busy_q;
    idx_d     = idx_q;
    type_d    = type_q;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        idx_d  = 4'd0;
        type_d = START;
        if (accept) begin
          state_d   = RUN;
          busy_d    = 1'b1;
          div_d     = div_in;
          nd_d      = nd_in;
          par_d     = parity_en;
          nbits_d   = nbits_in;
          bit_cnt_d = 4'd0;
          if (first_now) begin
            strobe_d  = 1'b1;
            bit_cnt_d = 4'd1;
          end
        end
      end
      RUN: begin
        if (abort || done_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          idx_d   = 4'd0;
          type_d  = START;
        end else if (tc) begin
          strobe_d  = 1'b1;
          idx_d     = bit_cnt_q;
          type_d    = decode_type(bit_cnt_q, nd_q, par_q);
          bit_cnt_d = bit_cnt_q + 4'd1;
          done_d    = (bit_cnt_q == nbits_q - 4'd1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      nd_q      <= 4'd0;
      nbits_q   <= 4'd0;
      bit_cnt_q <= 4'd0;
      par_q     <= 1'b0;
      strobe_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      idx_q     <= 4'd0;
      type_q    <= START;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      nd_q      <= nd_d;
      nbits_q   <= nbits_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      strobe_q  <= strobe_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      idx_q     <= idx_d;
      type_q    <= type_d;
    end
  end

  assign sample_strobe = strobe_q;
  assign packet_done   = done_q;
  assign busy          = busy_q;
  assign bit_index     = idx_q;
  assign bit_type      = type_q;

endmodule
